// File: rtl/ahb_mgr_arbiter.sv
// Two-manager AHB-Lite arbiter: round-robin address-phase grant onto one subordinate
// port, with capture/replay of the losing request and per-manager ready/response.
module ahb_mgr_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int STRB_W = 8
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [1:0][ADDR_W-1:0] MHADDR,
    input  logic [1:0]             MHWRITE,
    input  logic [1:0][2:0]        MHSIZE,
    input  logic [1:0][1:0]        MHTRANS,
    input  logic [1:0][DATA_W-1:0] MHWDATA,
    input  logic [1:0][STRB_W-1:0] MHWSTRB,
    output logic [1:0]             MHREADY,
    output logic [1:0]             MHRESP,
    output logic [ADDR_W-1:0]      HADDR,
    output logic                   HWRITE,
    output logic [2:0]             HSIZE,
    output logic [1:0]             HTRANS,
    output logic [DATA_W-1:0]      HWDATA,
    output logic [STRB_W-1:0]      HWSTRB,
    input  logic                   HREADY,
    input  logic                   HRESP,
    output logic [1:0]             Grant
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    logic [1:0]             pend_q, pend_d;
    logic [1:0]             out_q, out_d;
    logic [1:0]             own_q, own_d;
    logic                   last_q, last_d;
    logic [1:0][ADDR_W-1:0] addr_hold_q, addr_hold_d;
    logic [1:0]             write_hold_q, write_hold_d;
    logic [1:0][2:0]        size_hold_q, size_hold_d;

    logic [1:0] live;
    logic [1:0] req;
    logic [1:0] grant;
    logic       unused_trans_lsb;

    // SEQ collapses to NONSEQ and BUSY to IDLE, so only bit 1 of HTRANS matters.
    assign unused_trans_lsb = MHTRANS[0][0] ^ MHTRANS[1][0];

    // Live is gated by reset so an asserted reset forces IDLE and no grant at once.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            MHREADY[i] = ~out_q[i] | (own_q[i] & HREADY);
            live[i]    = HRESETn & MHREADY[i] & MHTRANS[i][1];
        end
        req    = live | pend_q;
        MHRESP = {2{HRESP}} & own_q;
    end

    always_comb begin
        grant = 2'b00;
        if (HREADY) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
        Grant = grant;
    end

    always_comb begin
        HADDR  = '0;
        HWRITE = 1'b0;
        HSIZE  = 3'b000;
        HTRANS = TRANS_IDLE;
        for (int i = 0; i < 2; i++) begin
            if (grant[i]) begin
                HTRANS = TRANS_NONSEQ;
                if (pend_q[i]) begin
                    HADDR  = addr_hold_q[i];
                    HWRITE = write_hold_q[i];
                    HSIZE  = size_hold_q[i];
                end else begin
                    HADDR  = MHADDR[i];
                    HWRITE = MHWRITE[i];
                    HSIZE  = MHSIZE[i];
                end
            end
        end
    end

    always_comb begin
        HWDATA = '0;
        HWSTRB = '0;
        if (own_q[0]) begin
            HWDATA = MHWDATA[0];
            HWSTRB = MHWSTRB[0];
        end else if (own_q[1]) begin
            HWDATA = MHWDATA[1];
            HWSTRB = MHWSTRB[1];
        end
    end

    always_comb begin
        pend_d       = pend_q;
        out_d        = out_q;
        addr_hold_d  = addr_hold_q;
        write_hold_d = write_hold_q;
        size_hold_d  = size_hold_q;
        own_d        = HREADY ? grant : own_q;
        last_d       = (grant != 2'b00) ? grant[1] : last_q;
        for (int i = 0; i < 2; i++) begin
            if (live[i] && !grant[i]) begin
                pend_d[i]       = 1'b1;
                addr_hold_d[i]  = MHADDR[i];
                write_hold_d[i] = MHWRITE[i];
                size_hold_d[i]  = MHSIZE[i];
            end else if (grant[i]) begin
                pend_d[i] = 1'b0;
            end
            // A new live request in the completing cycle keeps the transfer outstanding.
            if (live[i]) begin
                out_d[i] = 1'b1;
            end else if (own_q[i] && HREADY) begin
                out_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_q       <= 2'b00;
            out_q        <= 2'b00;
            own_q        <= 2'b00;
            last_q       <= 1'b1;
            addr_hold_q  <= '0;
            write_hold_q <= 2'b00;
            size_hold_q  <= '0;
        end else begin
            pend_q       <= pend_d;
            out_q        <= out_d;
            own_q        <= own_d;
            last_q       <= last_d;
            addr_hold_q  <= addr_hold_d;
            write_hold_q <= write_hold_d;
            size_hold_q  <= size_hold_d;
        end
    end

endmodule

// File: tb/tb_ahb_mgr_arbiter.sv
// Directed bench for ahb_mgr_arbiter: linear sequence of steps with hand-computed
// expected values, checked by immediate assertions.
module tb_ahb_mgr_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = 8;

    logic                   HCLK;
    logic                   HRESETn;
    logic [1:0][ADDR_W-1:0] MHADDR;
    logic [1:0]             MHWRITE;
    logic [1:0][2:0]        MHSIZE;
    logic [1:0][1:0]        MHTRANS;
    logic [1:0][DATA_W-1:0] MHWDATA;
    logic [1:0][STRB_W-1:0] MHWSTRB;
    logic [1:0]             MHREADY;
    logic [1:0]             MHRESP;
    logic [ADDR_W-1:0]      HADDR;
    logic                   HWRITE;
    logic [2:0]             HSIZE;
    logic [1:0]             HTRANS;
    logic [DATA_W-1:0]      HWDATA;
    logic [STRB_W-1:0]      HWSTRB;
    logic                   HREADY;
    logic                   HRESP;
    logic [1:0]             Grant;

    int checks   = 0;
    int failures = 0;

    ahb_mgr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .MHADDR(MHADDR), .MHWRITE(MHWRITE), .MHSIZE(MHSIZE), .MHTRANS(MHTRANS),
        .MHWDATA(MHWDATA), .MHWSTRB(MHWSTRB), .MHREADY(MHREADY), .MHRESP(MHRESP),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HTRANS(HTRANS),
        .HWDATA(HWDATA), .HWSTRB(HWSTRB), .HREADY(HREADY), .HRESP(HRESP),
        .Grant(Grant)
    );

    // Clock / reset
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Driver tasks
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_all();
        MHTRANS = '0;
        MHWRITE = '0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    logic [1:0]  exp_grant [6];
    logic [31:0] exp_addr  [6];

    initial begin
        HRESETn = 1'b0;
        HREADY  = 1'b1;
        HRESP   = 1'b0;
        MHADDR  = '0;
        MHWRITE = '0;
        MHSIZE  = '0;
        MHTRANS = '0;
        MHWDATA = '0;
        MHWSTRB = '0;
        settle();

        check("rst_htrans",  64'(HTRANS),  64'h0);
        check("rst_haddr",   64'(HADDR),   64'h0);
        check("rst_mhready", 64'(MHREADY), 64'h3);
        check("rst_mhresp",  64'(MHRESP),  64'h0);
        check("rst_grant",   64'(Grant),   64'h0);
        check("rst_hwdata",  64'(HWDATA),  64'h0);
        tick();
        HRESETn = 1'b1;
        tick();

        // Uncontended M0 read passes straight through
        MHADDR[0]  = 32'h8000_0000;
        MHSIZE[0]  = 3'd2;
        MHTRANS[0] = 2'b10;
        settle();
        check("t1_haddr",   64'(HADDR),   64'h8000_0000);
        check("t1_htrans",  64'(HTRANS),  64'h2);
        check("t1_hsize",   64'(HSIZE),   64'h2);
        check("t1_grant",   64'(Grant),   64'h1);
        check("t1_mhready", 64'(MHREADY), 64'h3);
        tick();
        idle_all();
        settle();
        check("t1_dp_mhready", 64'(MHREADY), 64'h3);
        check("t1_dp_grant",   64'(Grant),   64'h0);
        check("t1_dp_htrans",  64'(HTRANS),  64'h0);
        tick();

        // Fresh reset so manager 0 wins the first tie
        HRESETn = 1'b0;
        #2;
        HRESETn = 1'b1;
        tick();

        // Simultaneous requests: M0 first, M1 replayed from capture
        MHADDR[0]  = 32'h1000;
        MHADDR[1]  = 32'h2000;
        MHWRITE[1] = 1'b1;
        MHWDATA[1] = 64'h55;
        MHTRANS    = {2'b10, 2'b10};
        settle();
        check("t2_c0_grant",   64'(Grant),   64'h1);
        check("t2_c0_haddr",   64'(HADDR),   64'h1000);
        check("t2_c0_mhready", 64'(MHREADY), 64'h3);
        tick();
        idle_all();
        MHADDR = '0;
        settle();
        check("t2_c1_grant",   64'(Grant),   64'h2);
        check("t2_c1_haddr",   64'(HADDR),   64'h2000);
        check("t2_c1_hwrite",  64'(HWRITE),  64'h1);
        check("t2_c1_mhready", 64'(MHREADY), 64'h1);
        tick();
        settle();
        check("t2_c2_mhready", 64'(MHREADY), 64'h3);
        check("t2_c2_hwdata",  64'(HWDATA),  64'h55);
        check("t2_c2_grant",   64'(Grant),   64'h0);
        tick();

        // Both managers requesting continuously: strict alternation
        exp_grant = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        exp_addr  = '{32'hA0, 32'hB0, 32'hA0, 32'hB0, 32'hA0, 32'hB0};
        MHADDR[0] = 32'hA0;
        MHADDR[1] = 32'hB0;
        for (int c = 0; c < 6; c++) begin
            MHTRANS = {2'b10, 2'b10};
            settle();
            check($sformatf("t3_grant_%0d", c), 64'(Grant), 64'(exp_grant[c]));
            check($sformatf("t3_haddr_%0d", c), 64'(HADDR), 64'(exp_addr[c]));
            tick();
        end
        idle_all();
        settle();
        check("t3_replay_grant", 64'(Grant), 64'h1);
        check("t3_replay_haddr", 64'(HADDR), 64'hA0);
        tick();
        settle();
        check("t3_drain_grant", 64'(Grant), 64'h0);
        tick();

        // M1 write with 3 wait states, competing M0 request captured meanwhile
        MHADDR[1]  = 32'h3000;
        MHWRITE[1] = 1'b1;
        MHTRANS[1] = 2'b10;
        settle();
        check("t4_a_grant", 64'(Grant), 64'h2);
        tick();
        idle_all();
        MHWDATA[1] = 64'hDEAD_BEEF;
        MHWSTRB[1] = 8'h0F;
        MHWDATA[0] = 64'h1111;
        MHADDR[0]  = 32'h4000;
        MHTRANS[0] = 2'b10;
        HREADY     = 1'b0;
        settle();
        check("t4_b_hwdata",  64'(HWDATA),  64'hDEAD_BEEF);
        check("t4_b_mhready", 64'(MHREADY), 64'h1);
        check("t4_b_grant",   64'(Grant),   64'h0);
        check("t4_b_htrans",  64'(HTRANS),  64'h0);
        tick();
        MHTRANS[0] = 2'b00;
        MHADDR[0]  = '0;
        for (int c = 0; c < 2; c++) begin
            settle();
            check($sformatf("t4_ws_hwdata_%0d", c),  64'(HWDATA),  64'hDEAD_BEEF);
            check($sformatf("t4_ws_mhready_%0d", c), 64'(MHREADY), 64'h0);
            check($sformatf("t4_ws_grant_%0d", c),   64'(Grant),   64'h0);
            tick();
        end
        HREADY = 1'b1;
        settle();
        check("t4_e_grant",   64'(Grant),   64'h1);
        check("t4_e_haddr",   64'(HADDR),   64'h4000);
        check("t4_e_hwdata",  64'(HWDATA),  64'hDEAD_BEEF);
        check("t4_e_hwstrb",  64'(HWSTRB),  64'h0F);
        check("t4_e_mhready", 64'(MHREADY), 64'h2);
        tick();
        settle();
        check("t4_f_hwdata",  64'(HWDATA),  64'h1111);
        check("t4_f_mhready", 64'(MHREADY), 64'h3);
        check("t4_f_grant",   64'(Grant),   64'h0);
        tick();
        settle();
        check("t4_g_hwdata", 64'(HWDATA), 64'h0);

        // Two-cycle ERROR response on an M0 transfer
        MHADDR[0]  = 32'h5000;
        MHTRANS[0] = 2'b10;
        settle();
        check("t5_grant", 64'(Grant), 64'h1);
        tick();
        idle_all();
        HREADY = 1'b0;
        HRESP  = 1'b1;
        settle();
        check("t5_err1_mhresp",  64'(MHRESP),  64'h1);
        check("t5_err1_mhready", 64'(MHREADY), 64'h2);
        tick();
        HREADY = 1'b1;
        settle();
        check("t5_err2_mhresp",  64'(MHRESP),  64'h1);
        check("t5_err2_mhready", 64'(MHREADY), 64'h3);
        tick();
        HRESP = 1'b0;
        settle();
        check("t5_done_mhresp", 64'(MHRESP), 64'h0);
        tick();

        // Reset while M1 is pending and M0 owns a stalled data phase
        MHADDR[0]  = 32'h6000;
        MHTRANS[0] = 2'b10;
        settle();
        check("t6_m0_grant", 64'(Grant), 64'h1);
        tick();
        MHTRANS[0] = 2'b00;
        MHADDR[1]  = 32'h7000;
        MHTRANS[1] = 2'b10;
        HREADY     = 1'b0;
        settle();
        check("t6_capture_grant", 64'(Grant), 64'h0);
        tick();
        idle_all();
        settle();
        check("t6_pre_mhready", 64'(MHREADY), 64'h0);
        HRESETn = 1'b0;
        HREADY  = 1'b1;
        #1;
        check("t6_rst_htrans",  64'(HTRANS),  64'h0);
        check("t6_rst_mhready", 64'(MHREADY), 64'h3);
        check("t6_rst_grant",   64'(Grant),   64'h0);
        check("t6_rst_hwdata",  64'(HWDATA),  64'h0);
        tick();
        HRESETn = 1'b1;
        settle();
        check("t6_post_grant",  64'(Grant),  64'h0);
        check("t6_post_htrans", 64'(HTRANS), 64'h0);
        tick();
        settle();
        check("t6_post2_grant",   64'(Grant),   64'h0);
        check("t6_post2_mhready", 64'(MHREADY), 64'h3);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_mgr_arbiter.md
Name: ahb_mgr_arbiter

Overview:
Two-manager AHB-Lite arbiter that shares the single uncore AHB subordinate port between the core bus unit (manager 0) and a second bus manager such as a DMA or frame-fetch engine (manager 1).
- Arbitration is round-robin on address phases.
- A losing request is captured and replayed; the losing manager is stalled through its MHREADY.
- Read data from the subordinate (HRDATA) is broadcast to both managers outside this block, so it is not routed here.
- Supports single transfers only. SEQ is treated as NONSEQ; BUSY is treated as IDLE.

Parameters:
ADDR_W, 32, physical address width (PA_BITS)
DATA_W, 64, write data width (AHBW)
STRB_W, 8, write strobe width (DATA_W/8)

Ports:
HCLK  in  1  bus clock, the only clock
HRESETn  in  1  reset, asynchronous, active-low
MHADDR  in  [1:0][ADDR_W]  manager address, index = manager
MHWRITE  in  [1:0]  manager write
MHSIZE  in  [1:0][3]  manager size
MHTRANS  in  [1:0][2]  manager transfer type
MHWDATA  in  [1:0][DATA_W]  manager write data
MHWSTRB  in  [1:0][STRB_W]  manager write strobes
MHREADY  out  [1:0]  per-manager ready
MHRESP  out  [1:0]  per-manager error response
HADDR  out  ADDR_W  to subordinate
HWRITE  out  1  to subordinate
HSIZE  out  3  to subordinate
HTRANS  out  2  to subordinate
HWDATA  out  DATA_W  to subordinate
HWSTRB  out  STRB_W  to subordinate
HREADY  in  1  subordinate ready
HRESP  in  1  subordinate response
Grant  out  [1:0]  one-hot address-phase grant this cycle (debug/perf)

Behaviour:
State per manager i:
- Pending[i]: a captured, not-yet-issued request.
- Hold[i]: captured {addr, write, size}.
- Outstanding[i]: an accepted transfer not yet complete.

Shared state:
- DataOwner, 2-bit one-hot; 00 means no data phase.
- LastGrant, 1 bit.

Reset (async):
- Pending=0, Outstanding=0, DataOwner=00, LastGrant=1, so manager 0 wins the first tie.
- Outputs: HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, HWSTRB=0, MHREADY=11, MHRESP=00, Grant=00.

Combinational rules:
- MHREADY[i] = ~Outstanding[i] | (DataOwner[i] & HREADY).
- Live[i] = MHREADY[i] & MHTRANS[i][1]. Live and Pending are mutually exclusive.
- Req[i] = Live[i] | Pending[i].

Arbitration:
- Performed only when HREADY=1. If HREADY=0, Grant=00.
- One requester: grant it.
- Both requesting: grant ~LastGrant.
- LastGrant updates on each grant.

Address output:
- Granted i with Pending[i]: drive from Hold[i].
- Granted i otherwise: pass MHADDR/MHWRITE/MHSIZE through live, with zero added latency.
- HTRANS=NONSEQ when granted, else IDLE with HADDR, HWRITE, HSIZE = 0.

Capture:
- Live[i] & ~Grant[i] loads Hold[i] and sets Pending[i].
- Grant[i] clears Pending[i].

Outstanding:
- Set on Live[i].
- Cleared when DataOwner[i] & HREADY, unless Live[i] occurs in the same cycle (back-to-back), in which case it stays set.

Data phase:
- On HREADY=1, DataOwner <= Grant. It holds while HREADY=0.
- HWDATA/HWSTRB are muxed by DataOwner, or 0 when DataOwner=00.
- A stalled manager keeps its write data stable because its MHREADY is low.

Response:
- MHRESP[i] = HRESP & DataOwner[i]. The two-cycle ERROR pattern passes through.

Latency:
- Uncontended: the same as a direct connection.
- Contended loser: its data phase completes at least 1 cycle after the winner's.

Invariants:
- At most one DataOwner bit is set.
- Each manager has at most 1 outstanding transfer.
- Issuing while Pending is impossible.

Reset mid-transfer:
- All state clears immediately.
- Any in-flight or captured transfer is dropped with no replay.

Test Plan:
- M0 read to 0x8000_0000, M1 idle, HREADY=1 -> HADDR=0x8000_0000 and HTRANS=NONSEQ in the same cycle; Grant=01; MHREADY[0]=1 the next cycle; M1 never stalled.
- M0 and M1 both NONSEQ in the same cycle after reset (M0 addr 0x1000, M1 addr 0x2000) -> M0 issued first; 0x2000 captured and issued the next cycle; MHREADY[1]=0 for 1 extra cycle; Grant sequence 01, 10.
- Both managers requesting continuously for 6 transfers -> Grant alternates 01, 10, 01, 10, 01, 10; no starvation.
- M1 write 0xDEADBEEF with HREADY held low 3 cycles -> HWDATA=0xDEADBEEF stable through the wait states; MHREADY[1]=0 for those 3 cycles; a competing M0 request is captured and issued only once HREADY=1.
- Subordinate returns ERROR (HRESP=1 for 2 cycles) on an M0 transfer -> MHRESP=01 for both cycles; MHRESP[1] stays 0.
- HRESETn asserted while M1 is Pending and M0 owns the data phase -> immediate HTRANS=IDLE, MHREADY=11, Grant=00; after release, no replay of the M1 transfer.
